// File: rtl/raster_scan_ctrl_if.sv
// rtl/raster_scan_ctrl_if.sv - Control inputs and coordinate stream bundle for raster_scan_ctrl
interface raster_scan_ctrl_if #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 10
);
    logic                start;
    logic                abort;
    logic [COL_BITS-1:0] img_width;
    logic [ROW_BITS-1:0] img_height;
    logic                out_ready;
    logic                out_valid;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                sol;
    logic                eol;
    logic                eof;
    logic                busy;
    logic                done;

    modport master (
        input  start, abort, img_width, img_height, out_ready,
        output out_valid, col, row, sol, eol, eof, busy, done
    );

    modport slave (
        output start, abort, img_width, img_height, out_ready,
        input  out_valid, col, row, sol, eol, eof, busy, done
    );
endinterface

// File: rtl/raster_scan_ctrl.sv
// rtl/raster_scan_ctrl.sv - Raster-order pixel coordinate sequencer with valid/ready output
module raster_scan_ctrl #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    raster_scan_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] w_lat_q, w_lat_d;
    logic [ROW_BITS-1:0] h_lat_q, h_lat_d;

    logic run;
    logic xfer;
    logic at_eol;
    logic at_last_row;

    assign run         = (state_q == RUN);
    assign xfer        = run && bus.out_ready;
    assign at_eol      = (col_q == w_lat_q);
    assign at_last_row = (row_q == h_lat_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        w_lat_d = w_lat_q;
        h_lat_d = h_lat_q;
        if (bus.abort) begin
            // Abort beats start, transfer and end of frame alike.
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    col_d = '0;
                    row_d = '0;
                    if (bus.start) begin
                        w_lat_d = bus.img_width;
                        h_lat_d = bus.img_height;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (!at_eol) begin
                            col_d = col_q + COL_BITS'(1);
                        end else if (!at_last_row) begin
                            col_d = '0;
                            row_d = row_q + ROW_BITS'(1);
                        end else begin
                            col_d   = '0;
                            row_d   = '0;
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            w_lat_q <= '0;
            h_lat_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            w_lat_q <= w_lat_d;
            h_lat_q <= h_lat_d;
        end
    end

    assign bus.out_valid = run;
    assign bus.busy      = run;
    assign bus.done      = (state_q == DONE);
    assign bus.col       = col_q;
    assign bus.row       = row_q;
    assign bus.sol       = run && (col_q == '0);
    assign bus.eol       = run && at_eol;
    assign bus.eof       = run && at_eol && at_last_row;
endmodule

// File: doc/raster_scan_ctrl.md
# raster_scan_ctrl

Sequencer that walks an image frame in raster order (column fastest, then row) and emits one pixel coordinate per transfer on a valid/ready stream. It sits directly upstream of the flexible address/window counters in the edge-detector datapath. Its stream handshake is what those counters use as count enable. Its end-of-line and end-of-frame markers drive their clear inputs. Frame dimensions are sampled once per frame at start, so a new size can be programmed while a frame is in flight.

## Interface
- COL_BITS, default 10, width of column coordinate and width register
- ROW_BITS, default 10, width of row coordinate and height register
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  level/pulse; begins a frame when sampled high in IDLE
- abort  input  1  terminates any frame immediately; highest priority
- img_width  input  COL_BITS  last column index (columns = img_width+1)
- img_height  input  ROW_BITS  last row index (rows = img_height+1)
- out_ready  input  1  downstream accepts current coordinate
- out_valid  output  1  coordinate on col/row is valid
- col  output  COL_BITS  current column
- row  output  ROW_BITS  current row
- sol  output  1  start of line, col==0, qualified by out_valid
- eol  output  1  end of line, col==latched width, qualified by out_valid
- eof  output  1  last pixel of frame, eol and row==latched height
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the last transfer

## Operation
- States: IDLE, RUN, DONE. Registered state, registered outputs.
- IDLE:
  - out_valid=0.
  - col and row hold 0.
  - start=1 and abort=0: latch img_width into w_lat and img_height into h_lat, go to RUN.
- RUN:
  - out_valid=1, busy=1.
  - A transfer is out_valid && out_ready.
  - On a transfer with col!=w_lat: col<=col+1.
  - On a transfer with col==w_lat and row!=h_lat: col<=0, row<=row+1.
  - On a transfer with eof: col<=0, row<=0, go to DONE.
  - No transfer: col, row and the flags hold.
- DONE:
  - out_valid=0, busy=0, done=1 for exactly this cycle.
  - Unconditionally go to IDLE. start is ignored in DONE.
- abort=1 in any state: next state IDLE, col=row=0, no done pulse. abort overrides a same-cycle transfer, start or eof.
- start while in RUN is ignored. Changes to img_width/img_height during RUN have no effect.
- Arithmetic:
  - Comparisons are equality against the latched values.
  - Column increment never exceeds w_lat, so there is no wrap beyond COL_BITS.
  - Width 0 gives one column per line, so sol and eol are both high for every pixel.
  - Height 0 gives a single line.
  - Width 0 and height 0 give exactly one transfer.
- Transfers per frame = (w_lat+1)*(h_lat+1).
- sol, eol and eof are combinational decodes of the registered col/row/state against w_lat/h_lat. They are 0 whenever out_valid=0.

## Timing
- Reset values: state IDLE; out_valid, busy, done, sol, eol, eof = 0; col = 0; row = 0; w_lat = 0; h_lat = 0.
- Start latency:
  - start sampled high at edge k (IDLE) gives out_valid=1 with (0,0) after edge k.
  - The first transfer is possible in the cycle following edge k.
- Throughput: one coordinate per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, col, row, sol, eol and eof are stable.
- Last-transfer timing:
  - The last transfer is sampled at edge m.
  - done=1 and out_valid=0 after edge m.
  - IDLE after edge m+1.
  - The earliest next start is sampled at edge m+2, so there is a one-cycle minimum gap.
- Abort timing: abort sampled at edge a gives out_valid=0 and busy=0 after edge a.
- Asynchronous reset mid-frame: all outputs go to their reset values immediately. No done pulse.

## Test plan
- Reset and basic frame:
  - Stimulus: reset, then img_width=3, img_height=1, out_ready=1, one-cycle start.
  - Required: 8 transfers (0,0)..(3,0),(0,1)..(3,1).
  - Required: eol on col=3, eof only on (3,1).
  - Required: done pulses for exactly 1 cycle after the last transfer, then IDLE.
- Backpressure:
  - Stimulus: same frame, out_ready toggling 1,0,0,1 pattern.
  - Required: coordinates and flags hold during stalls, sequence identical to the basic frame, transfer count 8.
- Degenerate sizes:
  - Stimulus: img_width=0, img_height=0.
  - Required: exactly one transfer (0,0) with sol=eol=eof=1, then done.
  - Stimulus: img_width=0, img_height=2.
  - Required: 3 transfers, each with sol=eol=1.
- Abort:
  - Stimulus: abort asserted at (2,1) of a 4x4 frame (width=3, height=3).
  - Required: out_valid=0 next cycle, col=row=0, done never asserts.
  - Required: a subsequent start runs a full frame from (0,0).
- Size latching and start rules:
  - Stimulus: change img_width to 1 mid-frame.
  - Required: the frame completes with the original width.
  - Stimulus: start held high through DONE.
  - Required: the next frame begins 2 cycles after the last transfer, using the new width 1.
- Async reset mid-frame:
  - Stimulus: assert n_rst low at (1,0), independent of clk.
  - Required: all outputs 0 immediately, state IDLE after release.
